riscv_dbg_master: RTL

- Debug-bus initiator that drives the core's debug slave port: the SPR/GPR debug address space, plus the halt/step control with halt cause 0x1F.
- Accepts single high-level commands from a host-side adapter (JTAG/UART bridge): HALT, RESUME, STEP, READ, WRITE.
- Converts each command into one or more req/gnt/rvalid bus transactions, polling halt status where required.
- Returns exactly one response per command, carrying read data and an error flag.

---
 rtl/riscv_dbg_master.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/riscv_dbg_master.sv
// Debug-bus initiator: turns host HALT/RESUME/STEP/READ/WRITE commands into
// req/gnt/rvalid transactions on the core debug port, polling halt status as needed.
module riscv_dbg_master #(
   parameter int TIMEOUT_W = 8,
   parameter int ADDR_W    = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [2:0]        cmd_op_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [31:0]       cmd_wdata_i,
   output logic              resp_valid_o,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_err_o,
   output logic              dbg_req_o,
   input  logic              dbg_gnt_i,
   input  logic              dbg_rvalid_i,
   output logic [ADDR_W-1:0] dbg_addr_o,
   output logic              dbg_we_o,
   output logic [31:0]       dbg_wdata_o,
   input  logic [31:0]       dbg_rdata_i,
   input  logic              dbg_halted_i
);

   localparam logic [2:0] OP_HALT   = 3'd0;
   localparam logic [2:0] OP_RESUME = 3'd1;
   localparam logic [2:0] OP_STEP   = 3'd2;
   localparam logic [2:0] OP_READ   = 3'd3;
   localparam logic [2:0] OP_WRITE  = 3'd4;

   localparam logic [31:0] CTRL_HALT = 32'h0001_0000;
   localparam logic [31:0] CTRL_RUN  = 32'h0000_0000;
   localparam logic [31:0] CTRL_STEP = 32'h0000_0001;

   // Last count value before the wait budget of 2**TIMEOUT_W-1 cycles expires.
   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ILL,
      S_REQ,
      S_WAIT_RV,
      S_POLL_LO,
      S_POLL,
      S_RESP
   } state_t;

   state_t                state_reg;
   logic [2:0]            op_reg;
   logic [TIMEOUT_W-1:0]  cnt_reg;
   logic                  event_hit;

   // The event that ends each waiting state; it beats a simultaneous timeout.
   always_comb begin
      event_hit = 1'b0;
      case (state_reg)
         S_REQ:     event_hit = dbg_gnt_i;
         S_WAIT_RV: event_hit = dbg_rvalid_i;
         S_POLL_LO: event_hit = ~dbg_halted_i;
         S_POLL:    event_hit = dbg_halted_i;
         default:   event_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         op_reg       <= OP_HALT;
         cnt_reg      <= '0;
         cmd_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         dbg_req_o    <= 1'b0;
         dbg_we_o     <= 1'b0;
         dbg_addr_o   <= '0;
         dbg_wdata_o  <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  cmd_ready_o <= 1'b0;
                  op_reg      <= cmd_op_i;
                  cnt_reg     <= '0;
                  state_reg   <= S_REQ;
                  dbg_req_o   <= 1'b1;
                  dbg_we_o    <= 1'b1;
                  dbg_addr_o  <= '0;
                  case (cmd_op_i)
                     OP_HALT:   dbg_wdata_o <= CTRL_HALT;
                     OP_RESUME: dbg_wdata_o <= CTRL_RUN;
                     OP_STEP:   dbg_wdata_o <= CTRL_STEP;
                     OP_READ: begin
                        dbg_we_o    <= 1'b0;
                        dbg_addr_o  <= cmd_addr_i;
                        dbg_wdata_o <= cmd_wdata_i;
                     end
                     OP_WRITE: begin
                        dbg_addr_o  <= cmd_addr_i;
                        dbg_wdata_o <= cmd_wdata_i;
                     end
                     default: begin
                        dbg_req_o <= 1'b0;
                        dbg_we_o  <= 1'b0;
                        state_reg <= S_ILL;
                     end
                  endcase
               end
            end
            S_ILL: begin
               resp_valid_o <= 1'b1;
               resp_err_o   <= 1'b1;
               resp_rdata_o <= '0;
               state_reg    <= S_RESP;
            end
            S_RESP: begin
               resp_valid_o <= 1'b0;
               resp_err_o   <= 1'b0;
               resp_rdata_o <= '0;
               cmd_ready_o  <= 1'b1;
               state_reg    <= S_IDLE;
            end
            default: begin
               if (event_hit) begin
                  cnt_reg <= '0;
                  case (state_reg)
                     S_REQ: begin
                        dbg_req_o <= 1'b0;
                        state_reg <= S_WAIT_RV;
                     end
                     S_WAIT_RV: begin
                        if (op_reg == OP_HALT) begin
                           state_reg <= S_POLL;
                        end else if (op_reg == OP_STEP) begin
                           state_reg <= S_POLL_LO;
                        end else begin
                           resp_valid_o <= 1'b1;
                           resp_rdata_o <= (op_reg == OP_READ) ? dbg_rdata_i : 32'h0;
                           state_reg    <= S_RESP;
                        end
                     end
                     S_POLL_LO: state_reg <= S_POLL;
                     default: begin
                        resp_valid_o <= 1'b1;
                        state_reg    <= S_RESP;
                     end
                  endcase
               end else if (cnt_reg == CNT_LAST) begin
                  cnt_reg      <= '0;
                  dbg_req_o    <= 1'b0;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b1;
                  resp_rdata_o <= '0;
                  state_reg    <= S_RESP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         endcase
      end
   end

endmodule
